// File: rtl/calculadora_ctrl_if.sv
// Calculator control-stage bus: key pulses in, display value and flags out.
//   master : drives the key pulses (digit/op/eq/clear), reads display outputs
//   slave  : the control stage; reads key pulses, drives data_out/neg/overflow/busy
interface calculadora_ctrl_if #(
    parameter int unsigned WIDTH = 20
);
    logic             digit_valid;
    logic [3:0]       digit;
    logic             op_valid;
    logic [1:0]       op;
    logic             eq_valid;
    logic             clear;
    logic [WIDTH-1:0] data_out;
    logic             neg;
    logic             overflow;
    logic             busy;

    modport master (
        output digit_valid, digit, op_valid, op, eq_valid, clear,
        input  data_out, neg, overflow, busy
    );

    modport slave (
        input  digit_valid, digit, op_valid, op, eq_valid, clear,
        output data_out, neg, overflow, busy
    );
endinterface

// File: rtl/calculadora_ctrl.sv
// Calculator operand entry and arithmetic control stage.
// Accumulates decimal digits into operands A and B, runs add/sub in one cycle
// and mul (plus optional div) iteratively over WIDTH cycles, and presents a
// WIDTH-bit magnitude with sign/error flags to the BCD display stage.
// Ports:
//   clk    : system clock, all state on posedge
//   reset  : synchronous, active-high
//   bus    : calculadora_ctrl_if.slave (key pulses in; data_out/neg/overflow/busy out, all registered)
// Optional feature: define CALC_DIV_EN to enable op 11 = unsigned division
// (restoring divider); otherwise op 11 is ignored and no divider is built.
module calculadora_ctrl #(
    parameter int unsigned WIDTH   = 20,
    parameter int unsigned MAX_VAL = 999999
) (
    input  logic              clk,
    input  logic              reset,
    calculadora_ctrl_if.slave bus
);
    localparam int unsigned PROD_W  = 2 * WIDTH;
    localparam int unsigned ENTRY_W = WIDTH + 4;
    localparam int unsigned CNT_W   = $clog2(WIDTH);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {S_A, S_OP, S_B, S_CALC, S_RES, S_ERR} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, dout_q, dout_d;
    logic [1:0]          op_q, op_d;
    logic                neg_q, neg_d, ovf_q, ovf_d, busy_q, busy_d;
    logic [PROD_W-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Single-pulse decode: clear > eq > op > digit, lower pulses dropped
    logic do_clear, do_eq, do_op, do_digit;
    assign do_clear = bus.clear;
    assign do_eq    = bus.eq_valid & ~bus.clear;
    assign do_op    = bus.op_valid & ~bus.clear & ~bus.eq_valid;
    assign do_digit = bus.digit_valid & ~bus.clear & ~bus.eq_valid & ~bus.op_valid;

    logic op_ok, digit_ok, digit_fits, last_iter;
`ifdef CALC_DIV_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = (bus.op != OP_DIV);
`endif
    assign digit_ok  = (bus.digit <= 4'd9);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Decimal entry: shift the active operand one digit left and add the key
    logic [WIDTH-1:0]   entry_acc;
    logic [ENTRY_W-1:0] digit_nxt;
    assign entry_acc  = (state_q == S_B) ? b_q : a_q;
    assign digit_nxt  = ENTRY_W'(entry_acc) * ENTRY_W'(10) + ENTRY_W'(bus.digit);
    assign digit_fits = digit_ok && (digit_nxt <= ENTRY_W'(MAX_VAL));

    // Single-cycle add, checked one bit wider than the operands
    logic [WIDTH:0] sum_ab;
    logic           add_ovf;
    assign sum_ab  = (WIDTH + 1)'(a_q) + (WIDTH + 1)'(b_q);
    assign add_ovf = (sum_ab > (WIDTH + 1)'(MAX_VAL));

    // One iteration of the shift-add multiplier (and divider when enabled)
    logic [PROD_W-1:0] mul_acc_nxt, calc_res;
    logic              calc_ovf;
    assign mul_acc_nxt = acc_q + (shreg_q[0] ? mcand_q : '0);
`ifdef CALC_DIV_EN
    logic [WIDTH:0]   rem_shift, rem_nxt;
    logic             rem_ge;
    logic [WIDTH-1:0] quo_nxt;
    assign rem_shift = {acc_q[WIDTH-1:0], shreg_q[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, b_q});
    assign rem_nxt   = rem_ge ? (rem_shift - {1'b0, b_q}) : rem_shift;
    assign quo_nxt   = {shreg_q[WIDTH-2:0], rem_ge};
    assign calc_res  = (op_q == OP_DIV) ? PROD_W'(quo_nxt) : mul_acc_nxt;
`else
    assign calc_res  = mul_acc_nxt;
`endif
    assign calc_ovf = (calc_res > PROD_W'(MAX_VAL));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_A;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (do_clear) begin
            state_d = S_A;
        end else begin
            case (state_q)
                S_A:    if (do_op && op_ok) state_d = S_OP;
                S_OP:   if (do_digit && digit_ok) state_d = S_B;
                S_B: begin
                    if (do_eq) begin
                        case (op_q)
                            OP_ADD:  state_d = add_ovf ? S_ERR : S_RES;
                            OP_SUB:  state_d = S_RES;
                            OP_MUL:  state_d = S_CALC;
`ifdef CALC_DIV_EN
                            OP_DIV:  state_d = (b_q == '0) ? S_ERR : S_CALC;
`endif
                            default: state_d = S_ERR;
                        endcase
                    end
                end
                S_CALC: if (last_iter) state_d = calc_ovf ? S_ERR : S_RES;
                S_RES: begin
                    if (do_op && op_ok && !neg_q) state_d = S_OP;
                    else if (do_digit && digit_ok) state_d = S_A;
                end
                S_ERR:   state_d = S_ERR;
                default: state_d = S_A;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dout_d  = '0;
        if (do_clear) begin
            a_d   = '0;
            b_d   = '0;
            op_d  = OP_ADD;
            res_d = '0;
            neg_d = 1'b0;
            ovf_d = 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (do_digit && digit_fits) a_d = WIDTH'(digit_nxt);
                    else if (do_op && op_ok)    op_d = bus.op;
                end
                S_OP: begin
                    if (do_op && op_ok)            op_d = bus.op;
                    else if (do_digit && digit_ok) b_d = WIDTH'(bus.digit);
                end
                S_B: begin
                    if (do_digit && digit_fits) begin
                        b_d = WIDTH'(digit_nxt);
                    end else if (do_eq) begin
                        neg_d = 1'b0;
                        case (op_q)
                            OP_ADD: begin
                                ovf_d = add_ovf;
                                res_d = add_ovf ? '0 : WIDTH'(sum_ab);
                            end
                            OP_SUB: begin
                                neg_d = (a_q < b_q);
                                res_d = (a_q < b_q) ? (b_q - a_q) : (a_q - b_q);
                            end
                            OP_MUL: begin
                                acc_d   = '0;
                                mcand_d = PROD_W'(a_q);
                                shreg_d = b_q;
                                cnt_d   = '0;
                                busy_d  = 1'b1;
                            end
`ifdef CALC_DIV_EN
                            OP_DIV: begin
                                if (b_q == '0) begin
                                    ovf_d = 1'b1;
                                    res_d = '0;
                                end else begin
                                    acc_d   = '0;
                                    shreg_d = a_q;
                                    cnt_d   = '0;
                                    busy_d  = 1'b1;
                                end
                            end
`endif
                            default: begin
                                ovf_d = 1'b1;
                                res_d = '0;
                            end
                        endcase
                    end
                end
                S_CALC: begin
                    busy_d = !last_iter;
                    cnt_d  = cnt_q + CNT_W'(1);
`ifdef CALC_DIV_EN
                    if (op_q == OP_DIV) begin
                        acc_d   = PROD_W'(rem_nxt);
                        shreg_d = quo_nxt;
                    end else begin
                        acc_d   = mul_acc_nxt;
                        mcand_d = mcand_q << 1;
                        shreg_d = shreg_q >> 1;
                    end
`else
                    acc_d   = mul_acc_nxt;
                    mcand_d = mcand_q << 1;
                    shreg_d = shreg_q >> 1;
`endif
                    if (last_iter) begin
                        neg_d = 1'b0;
                        ovf_d = calc_ovf;
                        res_d = calc_ovf ? '0 : WIDTH'(calc_res);
                    end
                end
                S_RES: begin
                    if (do_op && op_ok && !neg_q) begin
                        a_d  = res_q;
                        op_d = bus.op;
                    end else if (do_digit && digit_ok) begin
                        a_d   = WIDTH'(bus.digit);
                        neg_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        // Display value follows the state being entered
        case (state_d)
            S_A, S_OP, S_CALC: dout_d = a_d;
            S_B:               dout_d = b_d;
            S_RES:             dout_d = res_d;
            default:           dout_d = '0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            res_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            acc_q   <= '0;
            mcand_q <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.data_out = dout_q;
    assign bus.neg      = neg_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_calculadora_ctrl.sv
// Testbench for calculadora_ctrl: directed key sequences plus random key
// pulses, every cycle compared against an arithmetic reference model.
module tb_calculadora_ctrl;
    localparam int unsigned WIDTH   = 20;
    localparam longint      MAX_VAL = 999999;

    localparam int M_A = 0, M_OP = 1, M_B = 2, M_CALC = 3, M_RES = 4, M_ERR = 5;

    logic clk = 1'b0;
    logic reset;

    calculadora_ctrl_if #(.WIDTH(WIDTH)) bus ();

    calculadora_ctrl #(.WIDTH(WIDTH), .MAX_VAL(999999)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: calculator mode plus operands held as plain integers
    int     m_mode;
    longint m_a, m_b, m_res, m_pend;
    int     m_op;
    bit     m_neg, m_ovf;
    int     m_left;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit op_allowed(input int o);
`ifdef CALC_DIV_EN
        return 1'b1;
`else
        return (o != 3);
`endif
    endfunction

    task automatic finish_result(input longint r, input bit n);
        if (r > MAX_VAL) begin
            m_mode = M_ERR; m_ovf = 1'b1; m_neg = 1'b0; m_res = 0;
        end else begin
            m_mode = M_RES; m_res = r; m_neg = n;
        end
    endtask

    task automatic model(input bit rst, input bit dv, input int d, input bit ov,
                         input int o, input bit ev, input bit clr);
        if (rst || clr) begin
            m_mode = M_A; m_a = 0; m_b = 0; m_res = 0; m_op = 0;
            m_neg = 1'b0; m_ovf = 1'b0; m_left = 0;
            return;
        end
        if (m_mode == M_CALC) begin
            m_left--;
            if (m_left == 0) finish_result(m_pend, 1'b0);
            return;
        end
        if (m_mode == M_ERR) return;
        if (ev) begin
            if (m_mode == M_B) begin
                case (m_op)
                    0: finish_result(m_a + m_b, 1'b0);
                    1: if (m_a >= m_b) finish_result(m_a - m_b, 1'b0);
                       else            finish_result(m_b - m_a, 1'b1);
                    2: begin m_pend = m_a * m_b; m_mode = M_CALC; m_left = WIDTH; end
                    default: begin
                        if (m_b == 0) finish_result(MAX_VAL + 1, 1'b0);
                        else begin m_pend = m_a / m_b; m_mode = M_CALC; m_left = WIDTH; end
                    end
                endcase
            end
        end else if (ov) begin
            if (op_allowed(o)) begin
                if (m_mode == M_A || m_mode == M_OP) begin
                    m_op = o; m_mode = M_OP;
                end else if (m_mode == M_RES && !m_neg) begin
                    m_a = m_res; m_op = o; m_mode = M_OP;
                end
            end
        end else if (dv && d <= 9) begin
            case (m_mode)
                M_A:   if (m_a * 10 + d <= MAX_VAL) m_a = m_a * 10 + d;
                M_B:   if (m_b * 10 + d <= MAX_VAL) m_b = m_b * 10 + d;
                M_OP:  begin m_b = d; m_mode = M_B; end
                M_RES: begin m_a = d; m_neg = 1'b0; m_mode = M_A; end
                default: ;
            endcase
        end
    endtask

    function automatic longint exp_dout();
        case (m_mode)
            M_A, M_OP, M_CALC: return m_a;
            M_B:               return m_b;
            M_RES:             return m_res;
            default:           return 0;
        endcase
    endfunction

    // Apply one cycle of inputs, advance the model, compare all outputs
    task automatic step(input bit rst, input bit dv, input int d, input bit ov,
                        input int o, input bit ev, input bit clr);
        reset           = rst;
        bus.digit_valid = dv;
        bus.digit       = 4'(d);
        bus.op_valid    = ov;
        bus.op          = 2'(o);
        bus.eq_valid    = ev;
        bus.clear       = clr;
        model(rst, dv, d, ov, o, ev, clr);
        @(posedge clk);
        #1;
        check("data_out", 64'(bus.data_out), 64'(exp_dout()));
        check("neg",      64'(bus.neg),      64'(m_neg));
        check("overflow", 64'(bus.overflow), 64'(m_ovf));
        check("busy",     64'(bus.busy),     64'(m_mode == M_CALC));
    endtask

    task automatic idle();      step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic key(int d);  step(0, 1, d, 0, 0, 0, 0); endtask
    task automatic opk(int o);  step(0, 0, 0, 1, o, 0, 0); endtask
    task automatic eqk();       step(0, 0, 0, 0, 0, 1, 0); endtask
    task automatic clr();       step(0, 0, 0, 0, 0, 0, 1); endtask
    task automatic rst();       step(1, 0, 0, 0, 0, 0, 0); endtask

    task automatic enter_num(input longint v);
        int ds[$];
        longint t;
        t = v;
        if (t == 0) ds.push_back(0);
        while (t > 0) begin
            ds.push_front(int'(t % 10));
            t = t / 10;
        end
        foreach (ds[i]) key(ds[i]);
    endtask

    // Idle through a busy period, returning how many cycles busy was seen high
    task automatic wait_busy(output int cnt);
        int guard;
        cnt = 0;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 40) begin
            cnt++;
            guard++;
            idle();
        end
    endtask

    initial begin
        int     busy_cnt;
        int     r;
        bit     dv, ov, ev, cl, rs;

        reset = 1'b1;
        bus.digit_valid = 1'b0; bus.digit = '0; bus.op_valid = 1'b0;
        bus.op = '0; bus.eq_valid = 1'b0; bus.clear = 1'b0;

        rst();
        check("rst_dout", 64'(bus.data_out), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);

        // Digit entry saturates at six digits
        for (int i = 1; i <= 6; i++) key(i);
        check("dig6", 64'(bus.data_out), 64'd123456);
        key(7);
        check("dig7", 64'(bus.data_out), 64'd123456);

        clr(); enter_num(250); opk(0); enter_num(750); eqk();
        check("add", 64'(bus.data_out), 64'd1000);
        check("add_neg", 64'(bus.neg), 64'd0);

        clr(); enter_num(25); opk(1); enter_num(100); eqk();
        check("sub", 64'(bus.data_out), 64'd75);
        check("sub_neg", 64'(bus.neg), 64'd1);
        opk(0);
        check("neg_chain", 64'(bus.data_out), 64'd75);

        clr(); enter_num(1234); opk(2); enter_num(567); eqk();
        wait_busy(busy_cnt);
        check("mul_busy", 64'(busy_cnt), 64'd20);
        check("mul", 64'(bus.data_out), 64'd699678);

        clr(); enter_num(1000); opk(2); enter_num(1000); eqk();
        wait_busy(busy_cnt);
        check("mul_ovf", 64'(bus.overflow), 64'd1);
        key(5);
        check("err_dig", 64'(bus.data_out), 64'd0);
        clr();
        check("err_clr", 64'(bus.overflow), 64'd0);

        clr(); enter_num(12); opk(2); enter_num(34); eqk();
        idle(); idle(); idle();
        rst();
        check("abort_busy", 64'(bus.busy), 64'd0);
        key(9);
        check("abort_dig", 64'(bus.data_out), 64'd9);

`ifdef CALC_DIV_EN
        clr(); enter_num(1000); opk(3); enter_num(7); eqk();
        wait_busy(busy_cnt);
        check("div_busy", 64'(busy_cnt), 64'd20);
        check("div", 64'(bus.data_out), 64'd142);
        clr(); enter_num(5); opk(3); enter_num(0); eqk();
        check("div0", 64'(bus.overflow), 64'd1);
`else
        clr(); enter_num(1000); opk(3);
        check("op11", 64'(bus.data_out), 64'd1000);
        key(5);
        check("op11_dig", 64'(bus.data_out), 64'd10005);
`endif

        // Random key pulses, occasionally overlapping
        clr();
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 99));
            dv = 1'b0; ov = 1'b0; ev = 1'b0; cl = 1'b0; rs = 1'b0;
            if      (r < 1)  rs = 1'b1;
            else if (r < 4)  cl = 1'b1;
            else if (r < 16) ev = 1'b1;
            else if (r < 30) ov = 1'b1;
            else if (r < 75) dv = 1'b1;
            if ($urandom_range(0, 19) == 0) dv = 1'b1;
            step(rs, dv, int'($urandom_range(0, 15)), ov, int'($urandom_range(0, 3)), ev, cl);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
